// File: rtl/tdc_measure_ctrl.sv
// tdc_measure_ctrl
//   Measurement sequencer for a CARRY4 tapped-delay-line TDC. It arms the
//   delay line and double-registers the tap thermometer code. When a hit
//   reaches the first tap, it captures popcount(taps) together with a coarse
//   count that is kept in lockstep with the tap pipeline. The resulting
//   timestamp is presented on a valid/ready handshake. After each hit the
//   line stays disarmed for DEAD_CYCLES so the chain can drain.
//
//   Optional build macro: TDC_AUTO_REARM_EN
//     defined   : DEAD returns straight to ARMED while enable is high.
//     undefined : single-shot; IDLE->ARMED needs a 0->1 edge of enable.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : measurement enable
//   taps        : raw delay-line CO outputs (asynchronous to clk)
//   arm         : hit gate into the delay line CYINIT
//   ts_fine     : popcount of captured thermometer code
//   ts_coarse   : coarse count aligned to the tap capture edge
//   ts_sat      : all taps were set (hit older than the chain)
//   ts_valid    : timestamp valid / ts_ready : consumer ready
//   busy        : FSM not in IDLE
//   glitch_cnt  : nonzero taps seen while disarmed, saturating at 255
module tdc_measure_ctrl #(
   parameter  int NCARRY4     = 2,
   parameter  int COARSE_W    = 16,
   parameter  int DEAD_CYCLES = 4,
   localparam int NTAPS       = 4 * NCARRY4,
   localparam int FINE_W      = $clog2(NTAPS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [NTAPS-1:0]    taps,
   output logic                arm,
   output logic [FINE_W-1:0]   ts_fine,
   output logic [COARSE_W-1:0] ts_coarse,
   output logic                ts_sat,
   output logic                ts_valid,
   input  logic                ts_ready,
   output logic                busy,
   output logic [7:0]          glitch_cnt
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ARMED  = 2'd1;
   localparam logic [1:0] OUTPUT = 2'd2;
   localparam logic [1:0] DEAD   = 2'd3;

   localparam int DW = $clog2(DEAD_CYCLES + 1);

   logic [1:0]          state;
   logic [DW-1:0]       dead_cnt;
   logic [NTAPS-1:0]    taps_s1, taps_s2;
   logic [COARSE_W-1:0] coarse_cnt, coarse_s1, coarse_s2;
   logic [FINE_W-1:0]   fine_c;
   logic                start, rearm;

`ifdef TDC_AUTO_REARM_EN
   assign start = enable;
   assign rearm = enable;
`else
   // Single-shot: only a fresh enable edge seen in IDLE starts a measurement.
   logic en_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) en_q <= 1'b0;
      else        en_q <= enable;
   end
   assign start = enable & ~en_q;
   assign rearm = 1'b0;
`endif

   // Population count tolerates bubbles in the thermometer code.
   always_comb begin
      fine_c = '0;
      for (int i = 0; i < NTAPS; i++)
         fine_c = fine_c + FINE_W'(taps_s2[i]);
   end

   assign arm      = (state == ARMED);
   assign ts_valid = (state == OUTPUT);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         dead_cnt   <= '0;
         taps_s1    <= '0;
         taps_s2    <= '0;
         coarse_cnt <= '0;
         coarse_s1  <= '0;
         coarse_s2  <= '0;
         ts_fine    <= '0;
         ts_coarse  <= '0;
         ts_sat     <= 1'b0;
         glitch_cnt <= '0;
      end else begin
         // s1 is the metastability stage; coarse follows the taps stage for
         // stage, so coarse_s2 is the count at the edge that sampled taps_s2.
         taps_s1    <= taps;
         taps_s2    <= taps_s1;
         coarse_cnt <= coarse_cnt + COARSE_W'(1);
         coarse_s1  <= coarse_cnt;
         coarse_s2  <= coarse_s1;

         if ((state == IDLE || state == DEAD) && (|taps_s2) && glitch_cnt != 8'hFF)
            glitch_cnt <= glitch_cnt + 8'd1;

         case (state)
            IDLE: if (start) state <= ARMED;
            ARMED: begin
               if (taps_s2[0]) begin
                  ts_fine   <= fine_c;
                  ts_sat    <= &taps_s2;
                  ts_coarse <= coarse_s2;
                  state     <= OUTPUT;
               end else if (!enable) begin
                  state <= DEAD;
               end
            end
            OUTPUT: if (ts_ready) state <= DEAD;
            default: begin
               if (dead_cnt == DW'(DEAD_CYCLES - 1)) begin
                  dead_cnt <= '0;
                  state    <= rearm ? ARMED : IDLE;
               end else begin
                  dead_cnt <= dead_cnt + DW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
module tb_tdc_measure_ctrl;
   localparam int NT = 8, CW = 8, FW = 4, DEAD = 4;
`ifdef TDC_AUTO_REARM_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, ts_ready = 1'b0;
   logic [NT-1:0] taps = '0;
   logic          arm, ts_sat, ts_valid, busy;
   logic [FW-1:0] ts_fine;
   logic [CW-1:0] ts_coarse;
   logic [7:0]    glitch_cnt;

   tdc_measure_ctrl #(.NCARRY4(2), .COARSE_W(CW), .DEAD_CYCLES(DEAD)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .taps(taps), .arm(arm),
      .ts_fine(ts_fine), .ts_coarse(ts_coarse), .ts_sat(ts_sat),
      .ts_valid(ts_valid), .ts_ready(ts_ready), .busy(busy),
      .glitch_cnt(glitch_cnt));

   always #5 clk = ~clk;

   // Reference time base: edges since reset release == free-running count.
   int cyc;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One hit from ARMED through accept and dead time.
   task automatic hit(input logic [NT-1:0] pat, input int stall);
      logic [CW-1:0] ec;
      logic [FW-1:0] ef;
      int            now;
      now = cyc;
      ec  = now[CW-1:0];
      ef  = FW'($countones(pat));
      chk("pre_arm", arm, 1);
      taps = pat;
      tick;
      taps = '0;
      chk("no_valid_s1", ts_valid, 0);
      tick;
      chk("no_valid_s2", ts_valid, 0);
      chk("still_armed", arm, 1);
      tick;
      chk("valid", ts_valid, 1);
      chk("fine", ts_fine, ef);
      chk("coarse", ts_coarse, ec);
      chk("sat", ts_sat, (pat == '1));
      chk("arm_low_out", arm, 0);
      for (int i = 0; i < stall; i++) begin
         // A late hit while the output is held must not be captured.
         if (stall >= 6 && i == 1) taps = '1;
         if (i == 2) taps = '0;
         tick;
         chk("hold_valid", ts_valid, 1);
         chk("hold_fine", ts_fine, ef);
         chk("hold_coarse", ts_coarse, ec);
         chk("hold_arm", arm, 0);
      end
      ts_ready = 1'b1;
      tick;
      ts_ready = 1'b0;
      chk("accepted", ts_valid, 0);
      chk("dead_busy", busy, 1);
      for (int i = 0; i < DEAD - 1; i++) begin
         tick;
         chk("dead_busy", busy, 1);
         chk("dead_arm", arm, 0);
      end
      tick;
      if (AUTO && enable) chk("auto_rearm", arm, 1);
      else                chk("back_idle", busy, 0);
   endtask

   task automatic rearm_line;
      if (!(AUTO && enable)) begin
         enable = 1'b0;
         tick;
         enable = 1'b1;
         tick;
      end
      chk("rearm", arm, 1);
   endtask

   initial begin
      // Reset state
      repeat (3) tick;
      chk("rst_arm", arm, 0);
      chk("rst_valid", ts_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_glitch", glitch_cnt, 0);
      chk("rst_fine", ts_fine, 0);
      chk("rst_coarse", ts_coarse, 0);
      chk("rst_sat", ts_sat, 0);
      rst_n = 1'b1;
      tick;
      chk("idle_no_enable", busy, 0);

      // Single hit at coarse 100
      enable = 1'b1;
      tick;
      chk("armed", arm, 1);
      while (cyc % 256 != 100) tick;
      hit(8'h1F, 0);
      if (!AUTO) begin
         repeat (3) tick;
         chk("single_shot_idle", busy, 0);
      end
      rearm_line;

      // Bubble, then saturation with backpressure
      hit(8'b0011_1011, 0);
      rearm_line;
      hit(8'hFF, 10);
      rearm_line;

      // Coarse wrap
      while (cyc % 256 != 255) tick;
      hit(8'h07, 0);
      rearm_line;
      repeat ($urandom_range(0, 3)) tick;
      hit(8'h03, 0);
      rearm_line;

      // Randomized hits
      for (int n = 0; n < 8; n++) begin
         logic [NT-1:0] p;
         p = NT'($urandom_range(0, 255)) | NT'(1);
         repeat ($urandom_range(0, 15)) tick;
         hit(p, $urandom_range(0, 8));
         rearm_line;
      end

      // Taps without bit 0 do not trigger a capture
      taps = 8'h06;
      tick;
      taps = '0;
      repeat (4) tick;
      chk("no_trig_valid", ts_valid, 0);
      chk("no_trig_arm", arm, 1);

      // Disarm by dropping enable: dead time, then idle
      enable = 1'b0;
      tick;
      chk("disarm_busy", busy, 1);
      chk("disarm_arm", arm, 0);
      repeat (3) tick;
      chk("disarm_dead", busy, 1);
      tick;
      chk("disarm_idle", busy, 0);
      chk("glitch_zero", glitch_cnt, 0);

      // Glitch counting in IDLE, with saturation
      taps = 8'h01;
      tick;
      taps = '0;
      tick;
      tick;
      chk("glitch_one", glitch_cnt, 1);
      tick;
      chk("glitch_hold", glitch_cnt, 1);
      chk("glitch_no_ts", ts_valid, 0);
      taps = 8'h80;
      repeat (300) tick;
      taps = '0;
      chk("glitch_sat", glitch_cnt, 255);
      chk("glitch_sat_no_ts", ts_valid, 0);

      // Async reset while a timestamp is pending
      enable = 1'b1;
      tick;
      chk("arm_for_rst", arm, 1);
      taps = 8'h1F;
      tick;
      taps = '0;
      tick;
      tick;
      chk("pending_valid", ts_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", ts_valid, 0);
      chk("async_arm", arm, 0);
      chk("async_busy", busy, 0);
      chk("async_glitch", glitch_cnt, 0);
      tick;
      rst_n = 1'b1;
      tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
